// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: sequencer state encoding and default datapath sizing.
package cpu_defs_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 48;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with write enable and synchronous clear.
module hilo_reg
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we) begin
            hi_d = hi_in;
            lo_d = lo_in;
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer between control and the multicycle MULT/DIV units: latches operands,
// holds the unit run enable until done, captures HI/LO, and aborts hung units.
module muldiv_seq
    import cpu_defs_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 6          // 2**CNT_W must exceed TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             StartMult,
    input  logic             StartDiv,
    input  logic [WIDTH-1:0] RegAOut,
    input  logic [WIDTH-1:0] RegBOut,
    output logic [WIDTH-1:0] OpA,
    output logic [WIDTH-1:0] OpB,
    output logic             MultCtrl,
    input  logic             MultDone,
    input  logic [WIDTH-1:0] MultHIOut,
    input  logic [WIDTH-1:0] MultLOOut,
    output logic             DivCtrl,
    input  logic             DivDone,
    input  logic [WIDTH-1:0] DivHIOut,
    input  logic [WIDTH-1:0] DivLOOut,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             OpDone,
    output logic             DivZero,
    output logic             Timeout,
    output logic             UnitRst
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             mult_ctrl_q, mult_ctrl_d;
    logic             div_ctrl_q, div_ctrl_d;
    logic             busy_q, busy_d;
    logic             op_done_q, op_done_d;
    logic             div_zero_q, div_zero_d;
    logic             timeout_q, timeout_d;
    logic             unit_rst_q, unit_rst_d;

    logic             hilo_we;
    logic [WIDTH-1:0] hilo_hi, hilo_lo;
    logic             run_done;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        mult_ctrl_d = 1'b0;
        div_ctrl_d  = 1'b0;
        busy_d      = 1'b0;
        op_done_d   = 1'b0;
        div_zero_d  = 1'b0;
        timeout_d   = 1'b0;
        unit_rst_d  = 1'b0;
        hilo_we     = 1'b0;
        hilo_hi     = MultHIOut;
        hilo_lo     = MultLOOut;
        run_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (StartMult) begin
                    op_a_d      = RegAOut;
                    op_b_d      = RegBOut;
                    cnt_d       = '0;
                    mult_ctrl_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = MULT_RUN;
                end else if (StartDiv) begin
                    if (RegBOut == '0) begin
                        div_zero_d = 1'b1;
                    end else begin
                        op_a_d     = RegAOut;
                        op_b_d     = RegBOut;
                        cnt_d      = '0;
                        div_ctrl_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = DIV_RUN;
                    end
                end
            end

            MULT_RUN, DIV_RUN: begin
                // Only the active unit's done counts; done beats a same-cycle watchdog expiry.
                run_done = (state_q == MULT_RUN) ? MultDone : DivDone;
                if (state_q == DIV_RUN) begin
                    hilo_hi = DivHIOut;
                    hilo_lo = DivLOOut;
                end
                if (run_done) begin
                    hilo_we   = 1'b1;
                    op_done_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d  = 1'b1;
                    unit_rst_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    busy_d      = 1'b1;
                    mult_ctrl_d = (state_q == MULT_RUN);
                    div_ctrl_d  = (state_q == DIV_RUN);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            mult_ctrl_q <= 1'b0;
            div_ctrl_q  <= 1'b0;
            busy_q      <= 1'b0;
            op_done_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            timeout_q   <= 1'b0;
            unit_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            mult_ctrl_q <= mult_ctrl_d;
            div_ctrl_q  <= div_ctrl_d;
            busy_q      <= busy_d;
            op_done_q   <= op_done_d;
            div_zero_q  <= div_zero_d;
            timeout_q   <= timeout_d;
            unit_rst_q  <= unit_rst_d;
        end
    end

    hilo_reg #(
        .WIDTH(WIDTH)
    ) u_hilo (
        .clock (clock),
        .clr   (reset),
        .we    (hilo_we),
        .hi_in (hilo_hi),
        .lo_in (hilo_lo),
        .hi    (HI),
        .lo    (LO)
    );

    assign OpA      = op_a_q;
    assign OpB      = op_b_q;
    assign MultCtrl = mult_ctrl_q;
    assign DivCtrl  = div_ctrl_q;
    assign Busy     = busy_q;
    assign OpDone   = op_done_q;
    assign DivZero  = div_zero_q;
    assign Timeout  = timeout_q;
    assign UnitRst  = unit_rst_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with behavioural MULT/DIV unit models driven per cycle.
module tb_muldiv_seq;

    localparam int W   = 32;
    localparam int TMO = 48;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          StartMult = 1'b0, StartDiv = 1'b0;
    logic [W-1:0]  RegAOut = '0, RegBOut = '0;
    logic [W-1:0]  OpA, OpB, HI, LO;
    logic          MultCtrl, DivCtrl, Busy, OpDone, DivZero, Timeout, UnitRst;
    logic          MultDone = 1'b0, DivDone = 1'b0;
    logic [W-1:0]  MultHIOut = '0, MultLOOut = '0, DivHIOut = '0, DivLOOut = '0;

    always #5 clock = ~clock;

    muldiv_seq #(.WIDTH(W), .TIMEOUT(TMO), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .StartMult(StartMult), .StartDiv(StartDiv),
        .RegAOut(RegAOut), .RegBOut(RegBOut),
        .OpA(OpA), .OpB(OpB),
        .MultCtrl(MultCtrl), .MultDone(MultDone),
        .MultHIOut(MultHIOut), .MultLOOut(MultLOOut),
        .DivCtrl(DivCtrl), .DivDone(DivDone),
        .DivHIOut(DivHIOut), .DivLOOut(DivLOOut),
        .HI(HI), .LO(LO), .Busy(Busy), .OpDone(OpDone),
        .DivZero(DivZero), .Timeout(Timeout), .UnitRst(UnitRst)
    );

    typedef struct {
        bit          sm, sd, stale, noise, hang;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] ehi, elo;
        int          emc, edc, edone;
        bit          edz, eto;
    } vec_t;

    int tests = 0;
    int fails = 0;

    int          r_mc, r_dc, r_done_at;
    bit          r_dz, r_to, r_ur, r_ctrl_end, r_clear, r_busy_ok, r_busy_seen;
    logic [31:0] r_hi, r_lo, r_opa, r_opb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle after the terminating event.
    task automatic do_op(input vec_t v);
        int ucnt;
        bit stop;
        logic signed [63:0] prod;
        r_mc = 0; r_dc = 0; r_done_at = 0; r_dz = 0; r_to = 0; r_ur = 0;
        r_ctrl_end = 0; r_busy_ok = 1; r_busy_seen = 0;
        StartMult = v.sm; StartDiv = v.sd; RegAOut = v.a; RegBOut = v.b;
        if (v.stale) begin
            MultDone = 1'b1; MultHIOut = 32'hDEAD0000; MultLOOut = 32'h0000BEEF;
        end
        @(negedge clock);
        StartMult = 1'b0; StartDiv = 1'b0;
        ucnt = 0; stop = 0;
        for (int i = 1; i <= 200 && !stop; i++) begin
            if (MultCtrl) r_mc++;
            if (DivCtrl)  r_dc++;
            if (Busy) r_busy_seen = 1;
            if ((MultCtrl || DivCtrl) && !Busy) r_busy_ok = 0;
            if (OpDone || DivZero || Timeout) begin
                stop = 1;
                r_done_at = OpDone ? i : 0;
                r_dz = DivZero; r_to = Timeout; r_ur = UnitRst;
                r_ctrl_end = MultCtrl | DivCtrl;
                r_hi = HI; r_lo = LO; r_opa = OpA; r_opb = OpB;
            end
            MultDone = 1'b0; DivDone = 1'b0;
            if (!stop && (MultCtrl || DivCtrl)) begin
                ucnt++;
                if (!v.hang && ucnt == v.lat) begin
                    if (MultCtrl) begin
                        prod = $signed(OpA) * $signed(OpB);
                        MultHIOut = prod[63:32]; MultLOOut = prod[31:0]; MultDone = 1'b1;
                    end else begin
                        DivLOOut = $signed(OpA) / $signed(OpB);
                        DivHIOut = $signed(OpA) % $signed(OpB);
                        DivDone  = 1'b1;
                    end
                end else if (v.noise) begin
                    if (MultCtrl) begin
                        DivDone = 1'b1; DivHIOut = 32'hBAD0BAD0; DivLOOut = 32'h0BAD0BAD;
                    end else begin
                        MultDone = 1'b1; MultHIOut = 32'hBAD0BAD0; MultLOOut = 32'h0BAD0BAD;
                    end
                end
            end
            if (!stop) @(negedge clock);
        end
        MultDone = 1'b0; DivDone = 1'b0;
        @(negedge clock);
        r_clear = !(OpDone | DivZero | Timeout | UnitRst | Busy | MultCtrl | DivCtrl);
    endtask

    vec_t vecs[12];

    initial begin
        //            sm sd st nz hg  a             b             lat ehi           elo           emc edc edone dz to
        vecs[0]  = '{1, 0, 0, 0, 0, 32'd7,        32'hFFFFFFFD, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 0,  35,   0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 32'd5,        32'd0,        1,  32'hFFFFFFFF, 32'hFFFFFFEB, 0,  0,  0,    1, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 32'd100,      32'd7,        10, 32'd2,        32'd14,       0,  10, 11,   0, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 32'd2,        32'd3,        5,  32'd0,        32'd6,        5,  0,  6,    0, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 32'hFFFFFFF9, 32'd2,        3,  32'hFFFFFFFF, 32'hFFFFFFFD, 0,  3,  4,    0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h00000000, 34, 0,  35,   0, 0};
        vecs[6]  = '{1, 0, 0, 0, 0, 32'd3,        32'd5,        48, 32'd0,        32'd15,       48, 0,  49,   0, 0};
        vecs[7]  = '{1, 0, 0, 0, 1, 32'd11,       32'd11,       1,  32'd0,        32'd15,       48, 0,  0,    0, 1};
        vecs[8]  = '{1, 0, 0, 0, 0, 32'd4,        32'd4,        34, 32'd0,        32'd16,       34, 0,  35,   0, 0};
        vecs[9]  = '{1, 0, 1, 1, 0, 32'd6,        32'd7,        4,  32'd0,        32'd42,       4,  0,  5,    0, 0};
        vecs[10] = '{0, 1, 0, 1, 0, 32'd0,        32'd5,        1,  32'd0,        32'd0,        0,  1,  2,    0, 0};
        vecs[11] = '{0, 1, 0, 0, 1, 32'd9,        32'd3,        1,  32'd0,        32'd0,        0,  48, 0,    0, 1};

        repeat (3) @(negedge clock);
        check("rst_hilo",  {HI, LO}, 64'd0);
        check("rst_ops",   {OpA, OpB}, 64'd0);
        check("rst_flags", {57'd0, MultCtrl, DivCtrl, Busy, OpDone, DivZero, Timeout, UnitRst}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i]);
            check($sformatf("v%0d_hi", i),      r_hi, vecs[i].ehi);
            check($sformatf("v%0d_lo", i),      r_lo, vecs[i].elo);
            check($sformatf("v%0d_mctrl", i),   r_mc, vecs[i].emc);
            check($sformatf("v%0d_dctrl", i),   r_dc, vecs[i].edc);
            check($sformatf("v%0d_done_at", i), r_done_at, vecs[i].edone);
            check($sformatf("v%0d_divzero", i), r_dz, vecs[i].edz);
            check($sformatf("v%0d_timeout", i), r_to, vecs[i].eto);
            check($sformatf("v%0d_unitrst", i), r_ur, vecs[i].eto);
            check($sformatf("v%0d_ctrl_end", i), r_ctrl_end, 0);
            check($sformatf("v%0d_pulse_clr", i), r_clear, 1);
            check($sformatf("v%0d_busy_ok", i), r_busy_ok, 1);
            check($sformatf("v%0d_busy_seen", i), r_busy_seen, (vecs[i].emc + vecs[i].edc) > 0);
            if (!vecs[i].edz) begin
                check($sformatf("v%0d_opa", i), r_opa, vecs[i].a);
                check($sformatf("v%0d_opb", i), r_opb, vecs[i].b);
            end
        end

        // Reset in the middle of a multiply: everything clears, no completion afterwards.
        StartMult = 1'b1; RegAOut = 32'd9; RegBOut = 32'd9;
        @(negedge clock);
        StartMult = 1'b0;
        repeat (9) @(negedge clock);
        check("midrst_running", {62'd0, MultCtrl, Busy}, 64'd3);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_hilo",  {HI, LO}, 64'd0);
        check("midrst_ops",   {OpA, OpB}, 64'd0);
        check("midrst_flags", {57'd0, MultCtrl, DivCtrl, Busy, OpDone, DivZero, Timeout, UnitRst}, 64'd0);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clock);
                if (OpDone || Busy || MultCtrl || Timeout) seen++;
            end
            check("midrst_quiet", seen, 0);
        end
        do_op('{1, 0, 0, 0, 0, 32'd1, 32'd1, 34, 32'd0, 32'd1, 34, 0, 35, 0, 0});
        check("post_rst_lo", r_lo, 32'd1);
        check("post_rst_hi", r_hi, 32'd0);
        check("post_rst_done_at", r_done_at, 35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
